// File: rtl/codec_spi_master.sv
// Write-only SPI master (mode 0) for the audio codec control port.
// Sends one WIDTH-bit word MSB first per TRG/RDY handshake, with CS setup, hold and gap framing.
module codec_spi_master #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CLKDIV   = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA,
  input  logic             TRG,
  output logic             RDY,
  output logic             MOSI,
  output logic             SCK,
  output logic             CS
);

  localparam int unsigned MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned MAX_CNT = (CLKDIV > MAX_SH) ? CLKDIV : MAX_SH;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned BIT_W   = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLKDIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_d;
  logic [WIDTH-1:0]   shift, shift_d;
  logic               sck_q, sck_d;
  logic               cs_q, cs_d;
  logic               rdy_q, rdy_d;

  // MOSI is the shift register MSB; the register is cleared whenever CS is high.
  assign MOSI = shift[WIDTH-1];
  assign SCK  = sck_q;
  assign CS   = cs_q;
  assign RDY  = rdy_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_cnt_d;
      shift   <= shift_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next-state and next-output logic; outputs are registered from the *_d values.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    sck_d     = sck_q;
    cs_d      = cs_q;
    rdy_d     = rdy_q;

    unique case (state)
      IDLE: begin
        rdy_d = 1'b1;
        cs_d  = 1'b1;
        sck_d = 1'b0;
        // Accept gated by the registered RDY so the first cycle after reset cannot accept.
        if (TRG && rdy_q) begin
          shift_d = DATA;
          cnt_d   = '0;
          rdy_d   = 1'b0;
          cs_d    = 1'b0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state_d = HOLD;
            end else begin
              bit_cnt_d = bit_cnt + BIT_W'(1);
              shift_d   = {shift[WIDTH-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          shift_d = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt == DIV_LAST) begin
          cnt_d   = '0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_codec_spi_master.sv
// Bench for codec_spi_master: default and corner-parameter instances checked every cycle
// against an arithmetic waveform model, plus SCK-rise word decoding per frame.
module tb_codec_spi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        trg_a, trg_b;
  logic [15:0] data_a;
  logic [7:0]  data_b;
  logic        rdy_a, mosi_a, sck_a, cs_a;
  logic        rdy_b, mosi_b, sck_b, cs_b;

  int checks = 0;
  int errors = 0;
  int p = 0;
  bit armed = 1'b0;
  bit rst_prev = 1'b0;

  int cfg_w  [2] = '{16, 8};
  int cfg_c  [2] = '{4, 1};
  int cfg_su [2] = '{2, 1};
  int cfg_ho [2] = '{2, 1};

  bit          busy  [2] = '{1'b0, 1'b0};
  int          t0    [2] = '{0, 0};
  logic [15:0] word  [2];
  logic        prev_sck [2];
  logic        prev_cs  [2];
  logic [15:0] rx    [2];
  int          nrise [2] = '{0, 0};

  codec_spi_master #(.WIDTH(16), .CLKDIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut_a (
    .CLK(clk), .RESET(rst), .DATA(data_a), .TRG(trg_a),
    .RDY(rdy_a), .MOSI(mosi_a), .SCK(sck_a), .CS(cs_a)
  );

  codec_spi_master #(.WIDTH(8), .CLKDIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
    .CLK(clk), .RESET(rst), .DATA(data_b), .TRG(trg_b),
    .RDY(rdy_b), .MOSI(mosi_b), .SCK(sck_b), .CS(cs_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at period %0d: got %h expected %h", tag, p, got, exp);
    end
  endtask

  // Expected {cs, sck, mosi, rdy} in the current period, from accept time and the framing rules.
  function automatic logic [3:0] model_out(input int s);
    int d, w, c, su, ho, k, b;
    w  = cfg_w[s];
    c  = cfg_c[s];
    su = cfg_su[s];
    ho = cfg_ho[s];
    if (rst_prev) return 4'b1000;
    if (busy[s]) begin
      d = p - t0[s] - 1;
      if (d < su) return {1'b0, 1'b0, word[s][w-1], 1'b0};
      d = d - su;
      if (d < 2*c*w) begin
        k = d % (2*c);
        b = d / (2*c);
        return {1'b0, (k >= c), word[s][w-1-b], 1'b0};
      end
      d = d - 2*c*w;
      if (d < ho) return {1'b0, 1'b0, word[s][0], 1'b0};
      d = d - ho;
      if (d < c) return 4'b1000;
    end
    return 4'b1001;
  endfunction

  // One clock period: check outputs, decode frames, then drive inputs and advance the model.
  task automatic step(input logic r, input logic ta, input logic [15:0] da,
                      input logic tb, input logic [15:0] db);
    logic [3:0]  obs [2];
    logic [3:0]  exp [2];
    logic [15:0] mask;
    logic        tsel;
    @(negedge clk);
    p++;
    obs[0] = {cs_a, sck_a, mosi_a, rdy_a};
    obs[1] = {cs_b, sck_b, mosi_b, rdy_b};
    for (int s = 0; s < 2; s++) begin
      exp[s] = model_out(s);
      if (armed) begin
        check($sformatf("pins%0d", s), 32'(obs[s]), 32'(exp[s]));
        if (prev_cs[s] === 1'b1 && obs[s][3] === 1'b0) begin
          rx[s]    = '0;
          nrise[s] = 0;
        end
        if (obs[s][3] === 1'b0 && prev_sck[s] === 1'b0 && obs[s][2] === 1'b1) begin
          rx[s] = {rx[s][14:0], obs[s][1]};
          nrise[s]++;
        end
        if (prev_cs[s] === 1'b0 && obs[s][3] === 1'b1 && !rst_prev) begin
          mask = (cfg_w[s] == 16) ? 16'hFFFF : 16'h00FF;
          check($sformatf("word%0d", s), 32'(rx[s]), 32'(word[s] & mask));
          check($sformatf("edges%0d", s), 32'(nrise[s]), 32'(cfg_w[s]));
        end
      end
      prev_cs[s]  = obs[s][3];
      prev_sck[s] = obs[s][2];
    end
    rst    = r;
    trg_a  = ta;
    data_a = da;
    trg_b  = tb;
    data_b = db[7:0];
    for (int s = 0; s < 2; s++) begin
      tsel = (s == 0) ? ta : tb;
      if (r) begin
        busy[s] = 1'b0;
      end else if (exp[s][0] && tsel) begin
        busy[s] = 1'b1;
        t0[s]   = p;
        word[s] = (s == 0) ? da : {8'h00, db[7:0]};
      end
    end
    rst_prev = r;
    if (r) armed = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
  endtask

  initial begin
    logic        r, ta, tb;
    logic [15:0] da, db;
    rst    = 1'b1;
    trg_a  = 1'b0;
    trg_b  = 1'b0;
    data_a = '0;
    data_b = '0;

    // Reset held three cycles, then release
    repeat (3) step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    idle(5);

    // Single word with default parameters
    step(1'b0, 1'b1, 16'h1E00, 1'b0, 16'h0000);
    idle(140);

    // Back-to-back with TRG held high; DATA changes right after the first accept
    for (int i = 0; i < 140; i++)
      step(1'b0, 1'b1, (i == 0) ? 16'h0C00 : 16'h0E4A, 1'b0, 16'h0000);
    idle(140);

    // TRG while busy is ignored
    for (int i = 0; i < 200; i++)
      step(1'b0, (i == 0 || i == 50), (i == 50) ? 16'hFFFF : 16'h1201, 1'b0, 16'h0000);

    // Reset during bit 7 high phase, then a full word after release
    step(1'b0, 1'b1, 16'hAAAA, 1'b0, 16'h0000);
    idle(62);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    idle(4);
    step(1'b0, 1'b1, 16'h3C5A, 1'b0, 16'h0000);
    idle(140);

    // Corner-parameter instance
    step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0081);
    idle(25);

    // Random traffic on both instances with occasional resets
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 599) == 0);
      ta = ($urandom_range(0, 29) == 0);
      tb = ($urandom_range(0, 9) == 0);
      da = 16'($urandom);
      db = 16'($urandom);
      step(r, ta, da, tb, db);
    end
    idle(150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
